// File: rtl/riscv_pkg.sv
// Shared opcode/ALU constants and enums for the multi-cycle RV32 controller.
// Define RISCV_TRAP_ILLEGAL_EN to compile in the absorbing TRAP state.
package riscv_pkg;

  localparam int unsigned INSN_W    = 32;
  localparam int unsigned ALU_CTL_W = 4;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [ALU_CTL_W-1:0] ALU_AND = 4'b0000;
  localparam logic [ALU_CTL_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [ALU_CTL_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [ALU_CTL_W-1:0] ALU_SUB = 4'b0110;

`ifdef RISCV_TRAP_ILLEGAL_EN
  typedef enum logic [2:0] {
    ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_TRAP
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB
  } state_t;
`endif

  typedef enum logic [2:0] {
    CLS_R, CLS_IMM, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_ILLEGAL
  } insn_class_t;

endpackage

// File: rtl/riscv_ctrl_decode.sv
// Combinational instruction classifier: opcode/funct fields to class, ALU
// control, operand-B select and illegal flag.
module riscv_ctrl_decode
  import riscv_pkg::*;
(
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic [6:0]           funct7,
  output insn_class_t          cls_c,
  output logic [ALU_CTL_W-1:0] alu_ctl_c,
  output logic                 alu_src_c,
  output logic                 illegal_c
);

  always_comb begin
    cls_c     = CLS_ILLEGAL;
    alu_ctl_c = ALU_ADD;
    alu_src_c = 1'b0;
    case (opcode)
      OP_R: begin
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000: begin cls_c = CLS_R; alu_ctl_c = ALU_ADD; end
            3'b111: begin cls_c = CLS_R; alu_ctl_c = ALU_AND; end
            3'b110: begin cls_c = CLS_R; alu_ctl_c = ALU_OR;  end
            default: ;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          cls_c     = CLS_R;
          alu_ctl_c = ALU_SUB;
        end
      end
      // funct7 carries immediate bits for I-type, so it is not inspected
      OP_IMM: begin
        alu_src_c = 1'b1;
        case (funct3)
          3'b000: begin cls_c = CLS_IMM; alu_ctl_c = ALU_ADD; end
          3'b111: begin cls_c = CLS_IMM; alu_ctl_c = ALU_AND; end
          3'b110: begin cls_c = CLS_IMM; alu_ctl_c = ALU_OR;  end
          default: ;
        endcase
      end
      OP_LOAD: begin
        alu_src_c = 1'b1;
        if (funct3 == 3'b010) cls_c = CLS_LOAD;
      end
      OP_STORE: begin
        alu_src_c = 1'b1;
        if (funct3 == 3'b010) cls_c = CLS_STORE;
      end
      OP_BRANCH: begin
        alu_ctl_c = ALU_SUB;
        if (funct3 == 3'b000) cls_c = CLS_BRANCH;
      end
      default: ;
    endcase
    illegal_c = (cls_c == CLS_ILLEGAL);
  end

endmodule

// File: rtl/riscv_mc_ctrl.sv
// Multi-cycle RV32-subset main controller: FETCH/DECODE/EXEC/MEM/WB sequencing
// over ready/valid memory handshakes. RISCV_TRAP_ILLEGAL_EN enables the TRAP state.
module riscv_mc_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned INSTRET_W = 32
)(
  input  logic                 clk,
  input  logic                 rst,
  output logic                 imem_req,
  input  logic                 imem_ready,
  input  logic [INSN_W-1:0]    imem_rdata,
  output logic                 dmem_req,
  output logic                 dmem_we,
  input  logic                 dmem_ready,
  input  logic                 zero,
  output logic                 alu_src,
  output logic [ALU_CTL_W-1:0] ALUCtl,
  output logic [INSN_W-1:0]    ir,
  output logic                 pc_write,
  output logic                 pc_src,
  output logic                 reg_write,
  output logic                 mem_to_reg,
  output logic                 illegal_insn,
  output logic [INSTRET_W-1:0] instret
);

  state_t               state, next_state;
  insn_class_t          dec_cls, cls_q;
  logic [ALU_CTL_W-1:0] dec_alu_ctl;
  logic                 dec_alu_src;
  logic                 dec_illegal;
  logic                 retire_c;

  riscv_ctrl_decode u_decode (
    .opcode    (ir[6:0]),
    .funct3    (ir[14:12]),
    .funct7    (ir[31:25]),
    .cls_c     (dec_cls),
    .alu_ctl_c (dec_alu_ctl),
    .alu_src_c (dec_alu_src),
    .illegal_c (dec_illegal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_FETCH;
    else     state <= next_state;
  end

  // Next state and handshake/strobe outputs; everything is forced low in reset.
  always_comb begin
    next_state = state;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    retire_c   = 1'b0;
    if (!rst) begin
      case (state)
        ST_FETCH: begin
          imem_req = 1'b1;
          if (imem_ready) begin
            pc_write   = 1'b1;
            next_state = ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (dec_illegal) begin
`ifdef RISCV_TRAP_ILLEGAL_EN
            next_state = ST_TRAP;
`else
            retire_c   = 1'b1;
            next_state = ST_FETCH;
`endif
          end else begin
            next_state = ST_EXEC;
          end
        end
        ST_EXEC: begin
          case (cls_q)
            CLS_BRANCH: begin
              pc_write   = zero;
              pc_src     = 1'b1;
              retire_c   = 1'b1;
              next_state = ST_FETCH;
            end
            CLS_LOAD, CLS_STORE: next_state = ST_MEM;
            default:             next_state = ST_WB;
          endcase
        end
        ST_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = (cls_q == CLS_STORE);
          if (dmem_ready) begin
            if (cls_q == CLS_STORE) begin
              retire_c   = 1'b1;
              next_state = ST_FETCH;
            end else begin
              next_state = ST_WB;
            end
          end
        end
        ST_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = (cls_q == CLS_LOAD);
          retire_c   = 1'b1;
          next_state = ST_FETCH;
        end
`ifdef RISCV_TRAP_ILLEGAL_EN
        ST_TRAP: next_state = ST_TRAP;
`endif
        default: next_state = ST_FETCH;
      endcase
    end
  end

  // Instruction register, retire counter and decoded-control capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir      <= '0;
      instret <= '0;
      cls_q   <= CLS_ILLEGAL;
      ALUCtl  <= ALU_ADD;
      alu_src <= 1'b0;
    end else begin
      if (state == ST_FETCH && imem_ready) ir <= imem_rdata;
      if (retire_c) instret <= instret + INSTRET_W'(1);
      if (state == ST_DECODE) cls_q <= dec_cls;
      if (state == ST_DECODE && next_state == ST_EXEC) begin
        ALUCtl  <= dec_alu_ctl;
        alu_src <= dec_alu_src;
      end else if (!(next_state inside {ST_EXEC, ST_MEM, ST_WB})) begin
        ALUCtl  <= ALU_ADD;
        alu_src <= 1'b0;
      end
    end
  end

`ifdef RISCV_TRAP_ILLEGAL_EN
  // Sticky until reset once an illegal instruction reaches DECODE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) illegal_insn <= 1'b0;
    else     illegal_insn <= illegal_insn | (state == ST_DECODE && dec_illegal);
  end
`else
  assign illegal_insn = (state == ST_DECODE) && dec_illegal;
`endif

endmodule

// File: doc/riscv_mc_ctrl.md
# riscv_mc_ctrl

Multi-cycle main controller for the RV32 subset datapath: fetches instructions over a ready/valid-style memory handshake and decodes them. It sequences each instruction through fetch, decode, execute, memory and writeback states. It is the driving end of the ALU control interface: it produces `alu_src` and `ALUCtl` and consumes the ALU `zero` flag to resolve branches. It sits between instruction/data memory and the register file/ALU datapath.

## Interface
- `INSTRET_W`, 32, width of the retired-instruction counter
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `imem_req`  out  1  instruction fetch request, held until accepted
- `imem_ready`  in  1  fetch complete; `imem_rdata` valid this cycle
- `imem_rdata`  in  32  fetched instruction word
- `dmem_req`  out  1  data access request, held until accepted
- `dmem_we`  out  1  1 = store, 0 = load; valid while `dmem_req`
- `dmem_ready`  in  1  data access complete
- `zero`  in  1  ALU zero flag
- `alu_src`  out  1  0 = reg_two, 1 = immediate as ALU operand B
- `ALUCtl`  out  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB
- `ir`  out  32  latched instruction register
- `pc_write`  out  1  one-cycle PC load strobe
- `pc_src`  out  1  0 = PC+4, 1 = branch target (old_pc + imm, computed by datapath)
- `reg_write`  out  1  one-cycle register-file write strobe
- `mem_to_reg`  out  1  1 = writeback from load data, 0 = from ALU result
- `illegal_insn`  out  1  sticky illegal-instruction flag
- `instret`  out  INSTRET_W  retired-instruction count

## Operation
- Supported instructions: add/sub/and/or (op 0110011), addi/andi/ori (0010011), lw (0000011, f3 010), sw (0100011, f3 010), beq (1100011, f3 000). Everything else is illegal.
- ALUCtl mapping: add/addi/lw/sw → 0010; sub/beq → 0110; and/andi → 0000; or/ori → 0001.
- `alu_src` = 1 for I-type, lw and sw; 0 for R-type and beq.
- FSM states: FETCH, DECODE, EXEC, MEM, WB, TRAP.
  - FETCH: `imem_req`=1. On `imem_ready`: latch `ir`, pulse `pc_write` with `pc_src`=0, go to DECODE.
  - DECODE: classify `ir`. Illegal goes to TRAP or FETCH (see Configuration). Otherwise go to EXEC.
  - EXEC: drive the decoded `ALUCtl`/`alu_src`.
    - R/I-type → WB.
    - lw/sw → MEM.
    - beq: `pc_write` = `zero`, `pc_src`=1; retire; → FETCH.
  - MEM: `dmem_req`=1, `dmem_we` = (sw). On `dmem_ready`: lw → WB; sw retires → FETCH.
  - WB: `reg_write`=1, `mem_to_reg` = (lw); retire; → FETCH.
- `ALUCtl`/`alu_src` hold their decoded value from EXEC through MEM and WB. In FETCH/DECODE they are 0010/0.
- Retire: `instret` increments by 1 on the retiring cycle and wraps to 0 after all-ones.
- Handshake: once asserted, a request stays high until its ready is sampled high at a rising edge. Ready while the request is low is ignored. There is no timeout; the FSM waits indefinitely.

## Timing
- Reset values: state FETCH, `ir`=0, `instret`=0, `illegal_insn`=0, `ALUCtl`=0010, all other outputs 0.
- `imem_req` is asserted in the first cycle after reset deasserts.
- Cycles per instruction with zero-wait memory (ready in the same cycle as the request):
  - beq: 3
  - R/I-type: 4
  - sw: 4
  - lw: 5
- Each wait cycle on memory adds one cycle.
- `pc_write`, `reg_write` and the `instret` increment are single-cycle strobes.
- Reset asserted mid-operation drops `imem_req`/`dmem_req` immediately (asynchronous) and suppresses all pending strobes.

## Configuration
- `RISCV_TRAP_ILLEGAL_EN` defined:
  - Illegal instruction in DECODE → TRAP, with `illegal_insn` set.
  - TRAP is absorbing: no requests, no strobes. It is left only by reset.
- Not defined:
  - Illegal instruction is a NOP: DECODE → FETCH, retires (`instret`+1).
  - `illegal_insn` still pulses high for that one DECODE cycle (non-sticky).
  - The TRAP state is not compiled in.

## Structure
- Shared package `riscv_pkg` holds:
  - opcode constants (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH);
  - ALUCtl constants (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB);
  - the FSM state enum;
  - the instruction-class enum.
- Sub-module `riscv_ctrl_decode`: combinational decoder from `ir` to {class, ALUCtl, alu_src, illegal}. The FSM registers the decoder's outputs in DECODE.

## Test plan
- Fetch 0x002081B3 (add x3,x1,x2), zero-wait → `ALUCtl`=0010, `alu_src`=0 in EXEC; `reg_write`=1, `mem_to_reg`=0 in cycle 4; `instret` 0→1.
- Fetch 0x402081B3 (sub) then 0x00208463 (beq +8):
  - sub → ALUCtl 0110;
  - beq with `zero`=1 → `pc_write`=1, `pc_src`=1 in EXEC;
  - beq with `zero`=0 → no `pc_write` in EXEC;
  - 3 cycles for the beq.
- Fetch 0x0080A283 (lw x5,8(x1)) with `dmem_ready` delayed 2 cycles → `dmem_req`=1, `dmem_we`=0 held 3 cycles; then WB with `mem_to_reg`=1; 7 cycles total.
- Fetch 0x0050A623 (sw x5,12(x1)) → `dmem_we`=1, `alu_src`=1, ALUCtl 0010; no `reg_write`; next FETCH follows `dmem_ready`.
- Fetch 0xFFFFFFFF:
  - with `RISCV_TRAP_ILLEGAL_EN` → `illegal_insn` sticky, `imem_req` stays 0 until `rst`;
  - without it → one-cycle `illegal_insn` pulse, `instret`+1, next fetch issued.
- Assert `rst` during a MEM wait → `dmem_req` drops the same cycle; after release, FETCH with `instret`=0.
